s_term_dsp_wire_probe: RTL and testbench
========================================

S_TERM_DSP_WIRE_PROBE -- requirements
Module: s_term_dsp_wire_probe

Interface
REQ-001 Parameter DEPTH, default 16, capture buffer depth in words; SHALL be a power of two and at least 2.
REQ-002 Parameter W, default 52, captured word width; SHALL equal the sum of the probed bus widths.
REQ-003 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 N1BEG  in  4  north-bound single wires leaving the south terminal tile.
REQ-006 N2BEG  in  8  north-bound double wires, MID segment.
REQ-007 N2BEGb  in  8  north-bound double wires, END segment.
REQ-008 N4BEG  in  16  north-bound quad wires.
REQ-009 NN4BEG  in  16  north-bound double-quad wires.
REQ-010 arm  in  1  single-cycle request to start a capture.
REQ-011 abort  in  1  single-cycle request to cancel any activity.
REQ-012 trig_mask  in  W  per-bit trigger enable.
REQ-013 trig_value  in  W  pattern compared against the masked sample.
REQ-014 trig_edge  in  1  trigger mode select; used only under S_TERM_DSP_PROBE_EDGE_TRIG_EN.
REQ-015 busy  out  1  high in ARMED, CAPTURE and READOUT.
REQ-016 triggered  out  1  high from the trigger cycle until READOUT completes.
REQ-017 rd_valid, rd_ready, rd_data[W-1:0], rd_last  out/in/out/out  readout stream.

Function
REQ-018 The sample word SHALL be packed as {NN4BEG, N4BEG, N2BEGb, N2BEG, N1BEG}, with N1BEG[0] at bit 0 and NN4BEG[15] at bit 51.
REQ-019 Input stage: the sample SHALL be registered every cycle; a value present at edge k SHALL be compared and (if capturing) written at edge k+1.
REQ-020 States: IDLE, ARMED, CAPTURE and READOUT; the state register SHALL be a single encoded field.
REQ-021 IDLE -> ARMED on arm; arm SHALL be ignored in every other state.
REQ-022 In ARMED, pattern match is ((sample ^ trig_value) & trig_mask) == 0; on a match the block SHALL write the sample to word 0, set triggered, and enter CAPTURE.
REQ-023 trig_mask all zero SHALL trigger on the first ARMED cycle.
REQ-024 In CAPTURE, one word SHALL be written per cycle at incrementing addresses; after word DEPTH-1 is written the block SHALL enter READOUT, giving exactly DEPTH consecutive samples.
REQ-025 In READOUT, rd_valid SHALL be 1 and rd_data SHALL equal mem[rd_ptr]; rd_ptr SHALL advance only on rd_valid & rd_ready.
REQ-026 rd_last SHALL be high exactly while rd_ptr == DEPTH-1; on that transfer the block SHALL return to IDLE, clear triggered, and reset the pointers.
REQ-027 rd_data and rd_last SHALL hold stable while rd_valid & !rd_ready.
REQ-028 abort in any state SHALL force IDLE on the next edge: rd_valid drops, triggered clears, pointers zero; abort SHALL win over a simultaneous arm.
REQ-029 Pointers SHALL be $clog2(DEPTH) bits wide and wrap only via an explicit reset to 0, never by overflow.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, busy=0, triggered=0, rd_valid=0, rd_last=0, rd_data=0, pointers=0 and the input register=0; buffer contents need not be reset.
REQ-031 Reset deasserted mid-CAPTURE or mid-READOUT SHALL leave the block in IDLE, with no stale rd_valid.

Configuration
REQ-032 Macro S_TERM_DSP_PROBE_EDGE_TRIG_EN defined: when trig_edge=1, ARMED SHALL trigger when ((sample ^ prev_sample) & trig_mask) != 0; prev_sample is loaded on ARMED entry, so the first ARMED cycle never edge-triggers.
REQ-033 Macro undefined: trig_edge SHALL be ignored, only pattern match SHALL be used, and no prev_sample register SHALL exist.

Structure
REQ-034 A shared package s_term_dsp_probe_pkg SHALL hold the state enum, the bus widths (4/8/8/16/16) and the derived W.
REQ-035 One sub-module s_term_dsp_probe_mem (DEPTH x W, one write port, one async read port) SHALL hold the capture buffer.

Verification
REQ-036 Reset: assert resetn low mid-CAPTURE -> busy=0 and rd_valid=0 immediately; after release arm yields a fresh capture.
REQ-037 Pattern trigger: mask=0xF (N1BEG), value=0x5, drive N1BEG=0x5 at cycle 10 with a ramp on N4BEG -> word0 N1BEG=0x5; words 0..15 contain consecutive ramp values.
REQ-038 Backpressure: toggle rd_ready 1/0 in READOUT -> exactly 16 transfers, data stable during stalls, rd_last only on the 16th, then IDLE.
REQ-039 Abort plus arm in the same cycle during READOUT -> IDLE next cycle; the arm is ignored and busy=0.
REQ-040 Zero mask: arm with trig_mask=0 -> triggered asserted one cycle after ARMED entry.
REQ-041 With the macro defined: edge mode, mask bit 51, NN4BEG[15] toggles at cycle 20 -> word0 holds the post-toggle value; a static bus never triggers.

Source files
------------

// File: rtl/s_term_dsp_probe_pkg.sv
// Shared types and bus widths for the south-terminal DSP wire probe.
// The edge-trigger option is selected by the S_TERM_DSP_PROBE_EDGE_TRIG_EN macro in the top.
package s_term_dsp_probe_pkg;

    localparam int N1_W    = 4;
    localparam int N2_W    = 8;
    localparam int N2B_W   = 8;
    localparam int N4_W    = 16;
    localparam int NN4_W   = 16;
    localparam int PROBE_W = N1_W + N2_W + N2B_W + N4_W + NN4_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } probe_state_e;

    // N1BEG lands in the low bits, NN4BEG in the top bits.
    function automatic logic [PROBE_W-1:0] pack_sample(
        input logic [N1_W-1:0]  n1,
        input logic [N2_W-1:0]  n2,
        input logic [N2B_W-1:0] n2b,
        input logic [N4_W-1:0]  n4,
        input logic [NN4_W-1:0] nn4
    );
        return {nn4, n4, n2b, n2, n1};
    endfunction

endpackage

// File: rtl/s_term_dsp_probe_mem.sv
// Capture buffer for the wire probe: DEPTH x W, one synchronous write port and
// one asynchronous read port.
module s_term_dsp_probe_mem
    import s_term_dsp_probe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PROBE_W
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; every word is written by a capture
    // before the readout stream can expose it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/s_term_dsp_wire_probe.sv
// Logic-analyser style probe on the north-bound wires leaving the south terminal tile.
// Define S_TERM_DSP_PROBE_EDGE_TRIG_EN to add the trig_edge (change-detect) trigger mode.
module s_term_dsp_wire_probe
    import s_term_dsp_probe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PROBE_W
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic [3:0]    N1BEG,
    input  logic [7:0]    N2BEG,
    input  logic [7:0]    N2BEGb,
    input  logic [15:0]   N4BEG,
    input  logic [15:0]   NN4BEG,
    input  logic          arm,
    input  logic          abort,
    input  logic [W-1:0]  trig_mask,
    input  logic [W-1:0]  trig_value,
    input  logic          trig_edge,
    output logic          busy,
    output logic          triggered,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic          rd_last
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

    probe_state_e  state_q, state_d;
    logic [W-1:0]  sample_q, sample_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          triggered_q, triggered_d;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_rdata;
    logic          pattern_hit;
    logic          trig_hit;

    assign sample_d    = pack_sample(N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG);
    assign pattern_hit = ((sample_q ^ trig_value) & trig_mask) == '0;

`ifdef S_TERM_DSP_PROBE_EDGE_TRIG_EN
    logic [W-1:0] prev_sample_q;
    logic         edge_hit;

    assign edge_hit = ((sample_q ^ prev_sample_q) & trig_mask) != '0;
    assign trig_hit = trig_edge ? edge_hit : pattern_hit;

    // Loaded with the value entering sample_q, so the first ARMED cycle sees no change.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            prev_sample_q <= '0;
        end else if (state_q == ST_IDLE && arm && !abort) begin
            prev_sample_q <= sample_d;
        end else if (state_q == ST_ARMED) begin
            prev_sample_q <= sample_q;
        end
    end
`else
    logic unused_trig_edge;

    assign unused_trig_edge = trig_edge;
    assign trig_hit         = pattern_hit;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        triggered_d = triggered_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;

        if (abort) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            triggered_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        mem_we      = 1'b1;
                        mem_waddr   = '0;
                        wr_ptr_d    = AW'(1);
                        triggered_d = 1'b1;
                        state_d     = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        state_d  = ST_READOUT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
                ST_READOUT: begin
                    if (rd_ready) begin
                        if (rd_ptr_q == LAST_PTR) begin
                            rd_ptr_d    = '0;
                            triggered_d = 1'b0;
                            state_d     = ST_IDLE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            triggered_q <= triggered_d;
        end
    end

    s_term_dsp_probe_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (sample_q),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Outputs decode straight from state so reset clears them without a clock.
    assign busy      = (state_q != ST_IDLE);
    assign triggered = triggered_q;
    assign rd_valid  = (state_q == ST_READOUT);
    assign rd_last   = rd_valid && (rd_ptr_q == LAST_PTR);
    assign rd_data   = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_s_term_dsp_wire_probe.sv
// Directed, table-driven bench for s_term_dsp_wire_probe (DEPTH=16, W=52).
module tb_s_term_dsp_wire_probe;

    localparam int DEPTH = 16;
    localparam int W     = 52;

    logic          CLK;
    logic          resetn;
    logic [3:0]    N1BEG;
    logic [7:0]    N2BEG;
    logic [7:0]    N2BEGb;
    logic [15:0]   N4BEG;
    logic [15:0]   NN4BEG;
    logic          arm;
    logic          abort;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic          trig_edge;
    logic          busy;
    logic          triggered;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic          rd_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] value;
        int           exp_tc;
        bit           bp;
    } vec_t;

    vec_t vecs [6];

    s_term_dsp_wire_probe #(.DEPTH(DEPTH), .W(W)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .N1BEG      (N1BEG),
        .N2BEG      (N2BEG),
        .N2BEGb     (N2BEGb),
        .N4BEG      (N4BEG),
        .NN4BEG     (NN4BEG),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .busy       (busy),
        .triggered  (triggered),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stimulus at cycle c: N1BEG pulses 5 at c=10, N4BEG ramps from 0x100,
    // N2BEGb = ~c, NN4BEG[15] rises at c=3.
    function automatic logic [W-1:0] stim(input int c);
        logic [3:0]  n1;
        logic [7:0]  n2;
        logic [7:0]  n2b;
        logic [15:0] n4;
        logic [15:0] nn4;
        n1  = (c == 10) ? 4'h5 : 4'h0;
        n2  = 8'(c * 3);
        n2b = ~8'(c);
        n4  = 16'h0100 + 16'(c);
        nn4 = (c >= 3) ? (16'h8000 | 16'(c)) : 16'(c);
        return {nn4, n4, n2b, n2, n1};
    endfunction

    task automatic drive(input logic [W-1:0] s);
        N1BEG  = s[3:0];
        N2BEG  = s[11:4];
        N2BEGb = s[19:12];
        N4BEG  = s[35:20];
        NN4BEG = s[51:36];
    endtask

    // Arms, feeds stim(c) every cycle and returns the cycle whose sample matched.
    task automatic run_capture(input logic [W-1:0] mask, input logic [W-1:0] value,
                               input int exp_tc, output int tc);
        int c;
        trig_mask  = mask;
        trig_value = value;
        drive(stim(0));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_busy", 64'(busy), 64'd1);
        check("armed_not_yet_trig", 64'(triggered), 64'd0);
        tc = -1;
        c  = 1;
        while (!rd_valid && c < 100) begin
            drive(stim(c));
            tick();
            if (triggered && tc < 0) tc = c - 1;
            c++;
        end
        check("reach_readout", 64'(rd_valid), 64'd1);
        check("trigger_cycle", 64'(tc), 64'(exp_tc));
    endtask

    task automatic readout(input int tc, input bit bp);
        int k;
        int cyc;
        bit toggle;
        bit stalled;
        logic [W-1:0] held;
        k = 0; cyc = 0; toggle = 1'b1; stalled = 1'b0; held = '0;
        while (k < DEPTH && cyc < 200) begin
            rd_ready = bp ? toggle : 1'b1;
            toggle   = ~toggle;
            check("rd_valid", 64'(rd_valid), 64'd1);
            check("rd_data", 64'(rd_data), 64'(stim(tc + k)));
            check("rd_last", 64'(rd_last), 64'(k == DEPTH - 1));
            if (stalled) check("stall_stable", 64'(rd_data), 64'(held));
            held    = rd_data;
            stalled = !rd_ready;
            tick();
            if (rd_ready) k++;
            cyc++;
        end
        rd_ready = 1'b0;
        check("transfer_count", 64'(k), 64'(DEPTH));
        check("idle_after_read_busy", 64'(busy), 64'd0);
        check("idle_after_read_valid", 64'(rd_valid), 64'd0);
        check("idle_after_read_trig", 64'(triggered), 64'd0);
    endtask

    initial begin
        int tc;

        vecs[0] = '{mask: 52'h000000000000F, value: 52'h0000000000005, exp_tc: 10, bp: 1'b1};
        vecs[1] = '{mask: 52'h0000000000000, value: 52'h00000DEADBEEF, exp_tc: 0,  bp: 1'b0};
        vecs[2] = '{mask: 52'h00000FFFF00000, value: 52'h0000010700000, exp_tc: 7, bp: 1'b0};
        vecs[3] = '{mask: 52'h8000000000000, value: 52'h8000000000000, exp_tc: 3,  bp: 1'b1};
        vecs[4] = '{mask: 52'h00000000FF000, value: 52'h00000000FA000, exp_tc: 5,  bp: 1'b0};
        vecs[5] = '{mask: 52'h800000000000F, value: 52'h8000000000005, exp_tc: 10, bp: 1'b1};

        resetn = 1'b0; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0; trig_edge = 1'b0;
        trig_mask = '0; trig_value = '0;
        drive('0);
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_trig", 64'(triggered), 64'd0);
        check("reset_valid", 64'(rd_valid), 64'd0);
        check("reset_last", 64'(rd_last), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_capture(vecs[i].mask, vecs[i].value, vecs[i].exp_tc, tc);
            if (rd_valid) readout(vecs[i].exp_tc, vecs[i].bp);
            tick();
        end

        // Reset in the middle of a capture, then a fresh capture.
        trig_mask = '0;
        drive(stim(0));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (4) tick();
        check("mid_capture_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_valid", 64'(rd_valid), 64'd0);
        check("async_reset_trig", 64'(triggered), 64'd0);
        check("async_reset_data", 64'(rd_data), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("post_reset_idle", 64'(busy), 64'd0);
        run_capture(vecs[0].mask, vecs[0].value, vecs[0].exp_tc, tc);
        if (rd_valid) readout(vecs[0].exp_tc, 1'b0);

        // Abort together with arm while in READOUT.
        run_capture(vecs[1].mask, vecs[1].value, vecs[1].exp_tc, tc);
        rd_ready = 1'b0;
        tick();
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(rd_valid), 64'd0);
        check("abort_trig", 64'(triggered), 64'd0);
        tick();
        check("abort_arm_ignored", 64'(busy), 64'd0);
        run_capture(vecs[2].mask, vecs[2].value, vecs[2].exp_tc, tc);
        if (rd_valid) readout(vecs[2].exp_tc, 1'b0);

`ifdef S_TERM_DSP_PROBE_EDGE_TRIG_EN
        trig_edge  = 1'b1;
        trig_mask  = 52'h8000000000000;
        trig_value = '0;
        drive(52'h0123456789ABC);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (10) tick();
        check("edge_static_no_trig", 64'(triggered), 64'd0);
        drive(52'h8123456789ABC);
        tick();
        tick();
        check("edge_trig", 64'(triggered), 64'd1);
        for (int i = 0; i < 40 && !rd_valid; i++) tick();
        check("edge_word0", 64'(rd_data), 64'h0008123456789ABC);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        trig_edge = 1'b0;
        check("edge_abort_idle", 64'(busy), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
